multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control state machine of the multicycle RV32I core. Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
//  Drives the register-file write enable (WE3 <- RegWrite), IR/PC/memory enables and datapath mux selects.
//  Moore machine: every output is a function of the registered state only. PCWrite is the one exception; it also depends on Zero and Funct3.
//  The ALU decoder is a separate sibling block that consumes ALUOp.
// PARAMETERS
//  OP_WIDTH     7  opcode field width (Instr[6:0])
//  STATE_WIDTH  4  state register width; holds encodings 0..11
// PORTS
//  CLK        in   1  clock; all state updates on the rising edge
//  RST        in   1  asynchronous, active-low reset
//  Op         in   7  opcode from the instruction register; stable from DECODE onward
//  Funct3     in   3  Instr[14:12]; bit 0 selects beq (0) or bne (1)
//  Zero       in   1  ALU zero flag
//  PCWrite    out  1  PC enable = PCUpdate | (Branch & (Zero ^ Funct3[0]))
//  AdrSrc     out  1  memory address select: 0 = PC, 1 = ALUOut
//  MemWrite   out  1  data-memory write enable
//  IRWrite    out  1  instruction/OldPC register enable
//  RegWrite   out  1  register-file write enable (WE3)
//  ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
//  ALUSrcA    out  2  ALU A mux: 00 PC, 01 OldPC, 10 A-reg
//  ALUSrcB    out  2  ALU B mux: 00 B-reg, 01 ImmExt, 10 const 4
//  ALUOp      out  2  00 add, 01 sub (branch), 10 funct-decoded
//  IllegalOp  out  1  only when ILLEGAL_OP_TRAP_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state = FETCH, applied asynchronously. While reset is held, outputs equal the FETCH decode.
//  - Reset mid-instruction abandons the instruction. No write enable other than the FETCH set may be high while RST=0.
//  - Outputs not listed for a state are 0. ResultSrc/ALUSrc default to 00.
//  - State outputs:
//    FETCH(0)    AdrSrc=0 IRWrite=1 ALUSrcA=00 ALUSrcB=10 ALUOp=00 ResultSrc=10 PCUpdate=1
//    DECODE(1)   ALUSrcA=01 ALUSrcB=01 ALUOp=00 (branch target precompute)
//    MEMADR(2)   ALUSrcA=10 ALUSrcB=01 ALUOp=00
//    MEMREAD(3)  ResultSrc=00 AdrSrc=1
//    MEMWB(4)    ResultSrc=01 RegWrite=1
//    MEMWRITE(5) ResultSrc=00 AdrSrc=1 MemWrite=1
//    EXECR(6)    ALUSrcA=10 ALUSrcB=00 ALUOp=10
//    ALUWB(7)    ResultSrc=00 RegWrite=1
//    EXECI(8)    ALUSrcA=10 ALUSrcB=01 ALUOp=10
//    JAL(9)      ALUSrcA=01 ALUSrcB=10 ALUOp=00 ResultSrc=00 PCUpdate=1
//    BRANCH(10)  ALUSrcA=10 ALUSrcB=00 ALUOp=01 ResultSrc=00 Branch=1
//    TRAP(11)    all enables 0; only reachable with the macro defined
//  - Transitions:
//    FETCH->DECODE (always).
//    DECODE: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BRANCH.
//    MEMADR: lw -> MEMREAD, else -> MEMWRITE.
//    MEMREAD -> MEMWB -> FETCH. EXECR/EXECI/JAL -> ALUWB -> FETCH. MEMWRITE/BRANCH -> FETCH.
//  - Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, branch 3.
//  - Illegal encodings of the state register (12..15) force FETCH on the next edge.
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined:
//   - Unlisted opcode in DECODE -> TRAP. TRAP holds until reset; IllegalOp=1 while in TRAP.
//   - IllegalOp port exists and is 0 in all other states.
//  ILLEGAL_OP_TRAP_EN undefined:
//   - Unlisted opcode in DECODE -> FETCH (executes as a 2-cycle NOP).
//   - No IllegalOp port; TRAP encoding unused.
// STRUCTURE
//  - Shared package holds: state encodings, the six opcode constants, and ResultSrc/ALUSrcA/ALUSrcB/ALUOp code constants.
//  - Datapath muxes and the ALU decoder use the same package.
//  - Single module: state register + next-state block + output decode. No sub-module.
// TESTING
//  1. RST=0 mid-EXECR, then release -> state FETCH; IRWrite=1, PCWrite=1, RegWrite=0 on the first cycle.
//  2. Op=0000011 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB. RegWrite=1 only in cycle 5 with ResultSrc=01.
//  3. Op=0100011 -> 4 cycles. MemWrite=1 only in cycle 4 with AdrSrc=1. RegWrite never 1.
//  4. Op=1100011 in BRANCH:
//     - Funct3=000, Zero=1 -> PCWrite=1; Zero=0 -> PCWrite=0.
//     - Funct3=001, Zero=0 -> PCWrite=1.
//  5. Op=1101111 -> JAL: PCWrite=1, ALUSrcA=01; then ALUWB: RegWrite=1, ResultSrc=00.
//  6. Op=1111111:
//     - Macro defined -> TRAP, IllegalOp=1, held for 10 cycles.
//     - Macro undefined -> back to FETCH after DECODE.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and mux/ALU codes.
// Used by the control FSM, the datapath muxes and the ALU decoder.
package multicycle_control_fsm_pkg;

    localparam int OP_WIDTH    = 7;
    localparam int STATE_WIDTH = 4;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_LW     = 7'b0000011;
    localparam logic [OP_WIDTH-1:0] OP_SW     = 7'b0100011;
    localparam logic [OP_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_AREG  = 2'b10;

    localparam logic [1:0] SRCB_BREG = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core (Moore, except PCWrite which also sees Zero/Funct3).
// Optional macro ILLEGAL_OP_TRAP_EN: unlisted opcodes park the FSM in TRAP and raise IllegalOp.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4
// DECODE     | read registers, precompute branch target
// MEMADR     | compute load/store address
// MEMREAD    | read data memory
// MEMWB      | write loaded data to register file
// MEMWRITE   | write data memory
// EXECR      | R-type ALU operation
// ALUWB      | write ALU result to register file
// EXECI      | I-type ALU operation
// JAL        | PC <= target, ALUOut <= OldPC+4
// BRANCH     | compare, conditionally load target into PC
// TRAP       | illegal opcode, held until reset
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [OP_WIDTH-1:0] Op,
    input  logic [2:0]          Funct3,
    input  logic                Zero,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic [1:0]          ALUOp,
    output logic                IllegalOp
`else
    output logic [1:0]          ALUOp
`endif
);

    state_t state;
    state_t state_next;
    logic   pc_update;
    logic   branch;
    logic   unused_funct3;

    assign unused_funct3 = ^Funct3[2:1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW)  state_next = S_MEMADR;
                else if (Op == OP_RTYPE)         state_next = S_EXECR;
                else if (Op == OP_ITYPE)         state_next = S_EXECI;
                else if (Op == OP_JAL)           state_next = S_JAL;
                else if (Op == OP_BRANCH)        state_next = S_BRANCH;
                else
`ifdef ILLEGAL_OP_TRAP_EN
                    state_next = S_TRAP;
`else
                    state_next = S_FETCH;
`endif
            end
            S_MEMADR:   state_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_EXECI:    state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_BRANCH:   state_next = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     state_next = S_TRAP;
`endif
            // TRAP without the macro and encodings 12..15 recover through FETCH
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_BREG;
        ALUOp     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                pc_update = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_AREG;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_AREG;
                ALUSrcB = SRCB_BREG;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_EXECI: begin
                ALUSrcA = SRCA_AREG;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_AREG;
                ALUSrcB = SRCB_BREG;
                ALUOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Funct3[0] inverts the sense of Zero: beq takes on equal, bne on not-equal
    assign PCWrite = pc_update | (branch & (Zero ^ Funct3[0]));

`ifdef ILLEGAL_OP_TRAP_EN
    assign IllegalOp = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; outputs sampled 1 time unit after each rising edge.
module tb_multicycle_control_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] Op = 7'd0;
    logic [2:0] Funct3 = 3'd0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       IllegalOp;
`endif

    int checks = 0;
    int errors = 0;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
    logic [12:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

    localparam logic [12:0] E_FETCH    = 13'b1_0_0_1_0_10_00_10_00;
    localparam logic [12:0] E_DECODE   = 13'b0_0_0_0_0_00_01_01_00;
    localparam logic [12:0] E_MEMADR   = 13'b0_0_0_0_0_00_10_01_00;
    localparam logic [12:0] E_MEMREAD  = 13'b0_1_0_0_0_00_00_00_00;
    localparam logic [12:0] E_MEMWB    = 13'b0_0_0_0_1_01_00_00_00;
    localparam logic [12:0] E_MEMWRITE = 13'b0_1_1_0_0_00_00_00_00;
    localparam logic [12:0] E_EXECR    = 13'b0_0_0_0_0_00_10_00_10;
    localparam logic [12:0] E_ALUWB    = 13'b0_0_0_0_1_00_00_00_00;
    localparam logic [12:0] E_EXECI    = 13'b0_0_0_0_0_00_10_01_10;
    localparam logic [12:0] E_JAL      = 13'b1_0_0_0_0_00_01_10_00;
    localparam logic [12:0] E_BR_NT    = 13'b0_0_0_0_0_00_10_00_01;
    localparam logic [12:0] E_BR_T     = 13'b1_0_0_0_0_00_10_00_01;
    localparam logic [12:0] E_TRAP     = 13'b0_0_0_0_0_00_00_00_00;

    multicycle_control_fsm dut (
        .CLK       (CLK),
        .RST       (RST),
        .Op        (Op),
        .Funct3    (Funct3),
        .Zero      (Zero),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
`ifdef ILLEGAL_OP_TRAP_EN
        .ALUOp     (ALUOp),
        .IllegalOp (IllegalOp)
`else
        .ALUOp     (ALUOp)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL reset_held obs=%b exp=%b", obs, E_FETCH);
        end
        #4 RST = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL reset_release obs=%b exp=%b", obs, E_FETCH);
        end
        step();
        checks++;
        if (obs !== E_DECODE) begin
            errors++;
            $display("FAIL reset_first_decode obs=%b exp=%b", obs, E_DECODE);
        end
        Op = 7'b1111111;
        step();
        // with an unlisted opcode the default build returns to FETCH; trap build would park in TRAP
        RST = 1'b0;
        #1 RST = 1'b1;
    endtask

    task automatic test_reset_mid_exec();
        logic [12:0] exp_tail [3];
        exp_tail = '{E_DECODE, E_EXECR, E_ALUWB};
        Op = 7'b0110011;
        step();
        checks++;
        if (obs !== E_DECODE) begin
            errors++;
            $display("FAIL midrst_decode obs=%b exp=%b", obs, E_DECODE);
        end
        step();
        checks++;
        if (obs !== E_EXECR) begin
            errors++;
            $display("FAIL midrst_execr obs=%b exp=%b", obs, E_EXECR);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL midrst_async obs=%b exp=%b", obs, E_FETCH);
        end
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL midrst_held obs=%b exp=%b", obs, E_FETCH);
        end
        #4 RST = 1'b1;
        #1;
        checks++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL midrst_first_cycle IRWrite=%b PCWrite=%b RegWrite=%b exp 1 1 0",
                     IRWrite, PCWrite, RegWrite);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp_tail[i]) begin
                errors++;
                $display("FAIL midrst_rerun[%0d] obs=%b exp=%b", i, obs, exp_tail[i]);
            end
        end
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL midrst_return obs=%b exp=%b", obs, E_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [12:0] exp [5];
        exp = '{E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_FETCH};
        Op = 7'b0000011;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL lw_cycle%0d obs=%b exp=%b", i + 2, obs, exp[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [12:0] exp [4];
        exp = '{E_DECODE, E_MEMADR, E_MEMWRITE, E_FETCH};
        Op = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL sw_cycle%0d obs=%b exp=%b", i + 2, obs, exp[i]);
            end
        end
    endtask

    task automatic test_itype();
        logic [12:0] exp [4];
        exp = '{E_DECODE, E_EXECI, E_ALUWB, E_FETCH};
        Op = 7'b0010011;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL itype_cycle%0d obs=%b exp=%b", i + 2, obs, exp[i]);
            end
        end
    endtask

    task automatic test_jal();
        logic [12:0] exp [4];
        exp = '{E_DECODE, E_JAL, E_ALUWB, E_FETCH};
        Op = 7'b1101111;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL jal_cycle%0d obs=%b exp=%b", i + 2, obs, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3_tab [4];
        logic        z_tab  [4];
        logic [12:0] br_tab [4];
        f3_tab = '{3'b000, 3'b000, 3'b001, 3'b001};
        z_tab  = '{1'b1,   1'b0,   1'b0,   1'b1};
        br_tab = '{E_BR_T, E_BR_NT, E_BR_T, E_BR_NT};
        Op = 7'b1100011;
        for (int i = 0; i < 4; i++) begin
            Funct3 = f3_tab[i];
            Zero   = z_tab[i];
            step();
            checks++;
            if (obs !== E_DECODE) begin
                errors++;
                $display("FAIL branch%0d_decode obs=%b exp=%b", i, obs, E_DECODE);
            end
            step();
            checks++;
            if (obs !== br_tab[i]) begin
                errors++;
                $display("FAIL branch%0d f3=%b zero=%b obs=%b exp=%b",
                         i, Funct3, Zero, obs, br_tab[i]);
            end
            Zero = ~Zero;
            #1;
            checks++;
            if (PCWrite !== ~br_tab[i][12]) begin
                errors++;
                $display("FAIL branch%0d_zero_flip PCWrite=%b exp=%b", i, PCWrite, ~br_tab[i][12]);
            end
            step();
            checks++;
            if (obs !== E_FETCH) begin
                errors++;
                $display("FAIL branch%0d_return obs=%b exp=%b", i, obs, E_FETCH);
            end
        end
        Funct3 = 3'b000;
        Zero   = 1'b0;
    endtask

    task automatic test_illegal();
        Op = 7'b1111111;
        step();
        checks++;
        if (obs !== E_DECODE) begin
            errors++;
            $display("FAIL illegal_decode obs=%b exp=%b", obs, E_DECODE);
        end
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs !== E_TRAP || IllegalOp !== 1'b1) begin
                errors++;
                $display("FAIL illegal_trap%0d obs=%b IllegalOp=%b exp=%b 1", i, obs, IllegalOp, E_TRAP);
            end
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (obs !== E_FETCH || IllegalOp !== 1'b0) begin
            errors++;
            $display("FAIL illegal_reset obs=%b IllegalOp=%b exp=%b 0", obs, IllegalOp, E_FETCH);
        end
        #2 RST = 1'b1;
`else
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL illegal_nop obs=%b exp=%b", obs, E_FETCH);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops  [6];
        int         cpi  [6];
        int         n;
        ops = '{7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011, 7'b1101111, 7'b0110011};
        cpi = '{4, 3, 5, 4, 4, 4};
        for (int i = 0; i < 6; i++) begin
            Op = ops[i];
            n  = 1;
            step();
            while (IRWrite !== 1'b1 && n < 10) begin
                n++;
                step();
            end
            checks++;
            if (n !== cpi[i]) begin
                errors++;
                $display("FAIL b2b_cpi op=%b cycles=%0d exp=%0d", ops[i], n, cpi[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_lw();
        test_sw();
        test_itype();
        test_jal();
        test_branch();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
